// File: rtl/writeback_unit.sv
// writeback_unit: write-back stage of the multicycle MIPS core.
//
// On a start pulse in IDLE it latches the destination register, the write-back
// source and the load controls. For loads it waits for the memory read handshake
// and formats the returned word (byte/half extension, LWL/LWR merge). It then
// spends one cycle in WRITE, raising done and, unless suppressed, a single
// register-file write strobe.
//
// Ports:
//   i_clk, i_reset           clock, synchronous active-high reset
//   i_start                  launch write-back (sampled only in IDLE)
//   i_write_reg_rd[4:0]      destination register index
//   i_wb_src[1:0]            0 ALU, 1 load, 2 link, 3 no write
//   i_alu_result[31:0]       ALU result
//   i_link_addr[31:0]        return address
//   i_load_type[2:0]         0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR, 7 LW
//   i_byte_offset[1:0]       effective address bits [1:0]
//   i_rt_old[31:0]           current rt value for LWL/LWR merge
//   i_mem_readdata[31:0]     load data, lowest-address byte in [31:24]
//   i_mem_waitrequest        high while read data is not yet valid
//   o_busy                   high in WAIT_MEM and WRITE
//   o_done                   one-cycle pulse in WRITE
//   o_rf_write_enable        register-file write strobe
//   o_rf_write_reg[4:0]      register index for the write
//   o_rf_write_data[31:0]    formatted write data
module writeback_unit (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [4:0]  i_write_reg_rd,
    input  logic [1:0]  i_wb_src,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_link_addr,
    input  logic [2:0]  i_load_type,
    input  logic [1:0]  i_byte_offset,
    input  logic [31:0] i_rt_old,
    input  logic [31:0] i_mem_readdata,
    input  logic        i_mem_waitrequest,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_rf_write_enable,
    output logic [4:0]  o_rf_write_reg,
    output logic [31:0] o_rf_write_data
);

    typedef enum logic [1:0] {StIdle, StWaitMem, StWrite} state_e;

    localparam logic [1:0] SrcAlu  = 2'd0;
    localparam logic [1:0] SrcLoad = 2'd1;
    localparam logic [1:0] SrcLink = 2'd2;
    localparam logic [1:0] SrcNone = 2'd3;

    state_e      r_state;
    state_e      w_next_state;

    // Pending load context, captured at start.
    logic [4:0]  r_pend_reg;
    logic [1:0]  r_src;
    logic [2:0]  r_load_type;
    logic [1:0]  r_offset;
    logic [31:0] r_rt_old;

    // Output-facing registers; only updated when entering WRITE so they hold
    // their previous values while a load is waiting on memory.
    logic [4:0]  r_out_reg;
    logic [31:0] r_out_data;

    logic        w_accept;
    logic        w_capture;
    logic [31:0] w_load_data;
    logic [31:0] w_sel_data;

    assign w_accept  = (r_state == StIdle) && i_start;
    assign w_capture = (r_state == StWaitMem) && !i_mem_waitrequest;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_next_state = (i_wb_src == SrcLoad) ? StWaitMem : StWrite;
                end
            end
            StWaitMem: begin
                if (!i_mem_waitrequest) begin
                    w_next_state = StWrite;
                end
            end
            StWrite: w_next_state = StIdle;
            default: w_next_state = StIdle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_busy            = 1'b0;
        o_done            = 1'b0;
        o_rf_write_enable = 1'b0;
        unique case (r_state)
            StIdle: ;
            StWaitMem: o_busy = 1'b1;
            StWrite: begin
                o_busy            = 1'b1;
                o_done            = 1'b1;
                o_rf_write_enable = (r_src != SrcNone) && (r_out_reg != 5'd0);
            end
            default: ;
        endcase
    end

    assign o_rf_write_reg  = r_out_reg;
    assign o_rf_write_data = r_out_data;

    // Non-load data selection at start; SrcNone value is never written.
    always_comb begin
        w_sel_data = i_alu_result;
        if (i_wb_src == SrcLink) begin
            w_sel_data = i_link_addr;
        end
    end

    // Load formatting from the latched controls and the incoming read word.
    always_comb begin
        logic [7:0]  w_byte;
        logic [15:0] w_half;
        w_load_data = i_mem_readdata;
        unique case (r_offset)
            2'd0:    w_byte = i_mem_readdata[31:24];
            2'd1:    w_byte = i_mem_readdata[23:16];
            2'd2:    w_byte = i_mem_readdata[15:8];
            default: w_byte = i_mem_readdata[7:0];
        endcase
        // Bit 0 of the offset is ignored for halfwords.
        w_half = r_offset[1] ? i_mem_readdata[15:0] : i_mem_readdata[31:16];
        case (r_load_type)
            3'd1: w_load_data = {{24{w_byte[7]}}, w_byte};
            3'd2: w_load_data = {24'd0, w_byte};
            3'd3: w_load_data = {{16{w_half[15]}}, w_half};
            3'd4: w_load_data = {16'd0, w_half};
            3'd5: begin
                unique case (r_offset)
                    2'd0:    w_load_data = i_mem_readdata;
                    2'd1:    w_load_data = {i_mem_readdata[23:0], r_rt_old[7:0]};
                    2'd2:    w_load_data = {i_mem_readdata[15:0], r_rt_old[15:0]};
                    default: w_load_data = {i_mem_readdata[7:0], r_rt_old[23:0]};
                endcase
            end
            3'd6: begin
                unique case (r_offset)
                    2'd0:    w_load_data = {r_rt_old[31:8], i_mem_readdata[31:24]};
                    2'd1:    w_load_data = {r_rt_old[31:16], i_mem_readdata[31:16]};
                    2'd2:    w_load_data = {r_rt_old[31:24], i_mem_readdata[31:8]};
                    default: w_load_data = i_mem_readdata;
                endcase
            end
            default: w_load_data = i_mem_readdata;
        endcase
    end

    // ---------------- datapath latches ----------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pend_reg  <= 5'd0;
            r_src       <= SrcAlu;
            r_load_type <= 3'd0;
            r_offset    <= 2'd0;
            r_rt_old    <= 32'd0;
            r_out_reg   <= 5'd0;
            r_out_data  <= 32'd0;
        end else begin
            if (w_accept) begin
                r_pend_reg  <= i_write_reg_rd;
                r_src       <= i_wb_src;
                r_load_type <= i_load_type;
                r_offset    <= i_byte_offset;
                r_rt_old    <= i_rt_old;
                if (i_wb_src != SrcLoad) begin
                    r_out_reg  <= i_write_reg_rd;
                    r_out_data <= w_sel_data;
                end
            end
            if (w_capture) begin
                r_out_reg  <= r_pend_reg;
                r_out_data <= w_load_data;
            end
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  write_reg_rd;
    logic [1:0]  wb_src;
    logic [31:0] alu_result;
    logic [31:0] link_addr;
    logic [2:0]  load_type;
    logic [1:0]  byte_offset;
    logic [31:0] rt_old;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;
    logic        busy;
    logic        done;
    logic        rf_we;
    logic [4:0]  rf_reg;
    logic [31:0] rf_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    writeback_unit dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .i_start           (start),
        .i_write_reg_rd    (write_reg_rd),
        .i_wb_src          (wb_src),
        .i_alu_result      (alu_result),
        .i_link_addr       (link_addr),
        .i_load_type       (load_type),
        .i_byte_offset     (byte_offset),
        .i_rt_old          (rt_old),
        .i_mem_readdata    (mem_readdata),
        .i_mem_waitrequest (mem_waitrequest),
        .o_busy            (busy),
        .o_done            (done),
        .o_rf_write_enable (rf_we),
        .o_rf_write_reg    (rf_reg),
        .o_rf_write_data   (rf_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch a load with no wait states and return the outputs seen in WRITE.
    task automatic do_load(input logic [2:0] lt, input logic [1:0] k, input logic [31:0] rt,
                           input logic [31:0] m, input logic [4:0] rd,
                           output logic got_done, output logic we, output logic [31:0] data);
        write_reg_rd    = rd;
        wb_src          = 2'd1;
        load_type       = lt;
        byte_offset     = k;
        rt_old          = rt;
        mem_readdata    = m;
        mem_waitrequest = 1'b0;
        start           = 1'b1;
        tick();
        start = 1'b0;
        got_done = 1'b0;
        we       = 1'b0;
        data     = 32'd0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) begin
                got_done = 1'b1;
                we       = rf_we;
                data     = rf_data;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++;
        if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", rf_we); end
        n_checks++;
        if (rf_reg !== 5'd0) begin n_fail++; $display("FAIL reset_reg got %0d want 0", rf_reg); end
        n_checks++;
        if (rf_data !== 32'd0) begin
            n_fail++; $display("FAIL reset_data got %h want 00000000", rf_data);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_alu_write();
        write_reg_rd = 5'd8;
        wb_src       = 2'd0;
        alu_result   = 32'h1234_5678;
        start        = 1'b1;
        tick();
        // In WRITE; keep start high with other values, which must be ignored.
        write_reg_rd = 5'd9;
        alu_result   = 32'hDEAD_BEEF;
        n_checks++;
        if ({done, rf_we, busy} !== 3'b111) begin
            n_fail++; $display("FAIL alu_strobe got done/we/busy %b want 111", {done, rf_we, busy});
        end
        n_checks++;
        if (rf_reg !== 5'd8) begin n_fail++; $display("FAIL alu_reg got %0d want 8", rf_reg); end
        n_checks++;
        if (rf_data !== 32'h1234_5678) begin
            n_fail++; $display("FAIL alu_data got %h want 12345678", rf_data);
        end
        tick();
        start = 1'b0;
        n_checks++;
        if ({done, rf_we, busy} !== 3'b000) begin
            n_fail++; $display("FAIL alu_idle got done/we/busy %b want 000", {done, rf_we, busy});
        end
        n_checks++;
        if (rf_reg !== 5'd8 || rf_data !== 32'h1234_5678) begin
            n_fail++; $display("FAIL alu_hold got %0d/%h want 8/12345678", rf_reg, rf_data);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL start_in_write got busy %b want 0", busy); end
    endtask

    task automatic test_lb_wait();
        logic ok;
        write_reg_rd    = 5'd4;
        wb_src          = 2'd1;
        load_type       = 3'd1;
        byte_offset     = 2'd2;
        rt_old          = 32'h0;
        mem_readdata    = 32'h0;
        mem_waitrequest = 1'b1;
        start           = 1'b1;
        tick();
        start = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (busy !== 1'b1 || done !== 1'b0 || rf_we !== 1'b0) ok = 1'b0;
            tick();
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL lb_wait_busy got ok=%b want 1", ok); end
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL lb_wait_still got busy/done %b%b want 10", busy, done);
        end
        mem_readdata    = 32'h1122_8344;
        mem_waitrequest = 1'b0;
        tick();
        mem_readdata = 32'hFFFF_0000;
        #1;
        n_checks++;
        if ({done, rf_we} !== 2'b11 || rf_reg !== 5'd4) begin
            n_fail++; $display("FAIL lb_write got done/we %b reg %0d want 11 reg 4", {done, rf_we}, rf_reg);
        end
        n_checks++;
        if (rf_data !== 32'hFFFF_FF83) begin
            n_fail++; $display("FAIL lb_data got %h want ffffff83", rf_data);
        end
        tick();
        begin
            logic d, w;
            logic [31:0] v;
            do_load(3'd2, 2'd2, 32'h0, 32'h1122_8344, 5'd4, d, w, v);
            n_checks++;
            if (!d || !w || v !== 32'h0000_0083) begin
                n_fail++; $display("FAIL lbu_data got %h done %b we %b want 00000083", v, d, w);
            end
        end
    endtask

    task automatic test_merge();
        logic d, w;
        logic [31:0] v;
        do_load(3'd5, 2'd1, 32'h1122_3344, 32'hAABB_CCDD, 5'd10, d, w, v);
        n_checks++;
        if (!d || v !== 32'hBBCC_DD44) begin n_fail++; $display("FAIL lwl_k1 got %h want bbccdd44", v); end
        do_load(3'd6, 2'd1, 32'h1122_3344, 32'hAABB_CCDD, 5'd10, d, w, v);
        n_checks++;
        if (!d || v !== 32'h1122_AABB) begin n_fail++; $display("FAIL lwr_k1 got %h want 1122aabb", v); end
        do_load(3'd6, 2'd3, 32'h1122_3344, 32'hAABB_CCDD, 5'd10, d, w, v);
        n_checks++;
        if (!d || v !== 32'hAABB_CCDD) begin n_fail++; $display("FAIL lwr_k3 got %h want aabbccdd", v); end
        do_load(3'd3, 2'd3, 32'h0, 32'hAABB_CCDD, 5'd10, d, w, v);
        n_checks++;
        if (!d || v !== 32'hFFFF_CCDD) begin n_fail++; $display("FAIL lh_k3 got %h want ffffccdd", v); end
        do_load(3'd4, 2'd1, 32'h0, 32'hAABB_CCDD, 5'd10, d, w, v);
        n_checks++;
        if (!d || v !== 32'h0000_AABB) begin n_fail++; $display("FAIL lhu_k1 got %h want 0000aabb", v); end
        do_load(3'd7, 2'd2, 32'h0, 32'hAABB_CCDD, 5'd10, d, w, v);
        n_checks++;
        if (!d || v !== 32'hAABB_CCDD) begin n_fail++; $display("FAIL lw7 got %h want aabbccdd", v); end
    endtask

    task automatic test_no_write();
        write_reg_rd = 5'd0;
        wb_src       = 2'd0;
        alu_result   = 32'h5555_AAAA;
        start        = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if ({done, rf_we} !== 2'b10) begin
            n_fail++; $display("FAIL zero_reg got done/we %b want 10", {done, rf_we});
        end
        tick();
        write_reg_rd = 5'd5;
        wb_src       = 2'd3;
        start        = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if ({done, rf_we} !== 2'b10) begin
            n_fail++; $display("FAIL src_none got done/we %b want 10", {done, rf_we});
        end
        tick();
    endtask

    task automatic test_link();
        write_reg_rd = 5'd31;
        wb_src       = 2'd2;
        alu_result   = 32'h0000_1111;
        link_addr    = 32'hBFC0_0008;
        start        = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if ({done, rf_we} !== 2'b11 || rf_reg !== 5'd31 || rf_data !== 32'hBFC0_0008) begin
            n_fail++; $display("FAIL link got we %b reg %0d data %h want 1 31 bfc00008",
                               rf_we, rf_reg, rf_data);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        logic saw_we;
        write_reg_rd    = 5'd7;
        wb_src          = 2'd1;
        load_type       = 3'd0;
        byte_offset     = 2'd0;
        mem_readdata    = 32'hCAFE_F00D;
        mem_waitrequest = 1'b1;
        start           = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset           = 1'b0;
        mem_waitrequest = 1'b0;
        n_checks++;
        if ({busy, done, rf_we} !== 3'b000 || rf_reg !== 5'd0 || rf_data !== 32'd0) begin
            n_fail++; $display("FAIL abort_outputs got b/d/we %b reg %0d data %h want 000 0 0",
                               {busy, done, rf_we}, rf_reg, rf_data);
        end
        saw_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rf_we || done) saw_we = 1'b1;
        end
        n_checks++;
        if (saw_we) begin n_fail++; $display("FAIL abort_no_strobe got %b want 0", saw_we); end
        write_reg_rd = 5'd3;
        wb_src       = 2'd0;
        alu_result   = 32'h0BAD_CAFE;
        start        = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (!rf_we || rf_reg !== 5'd3 || rf_data !== 32'h0BAD_CAFE) begin
            n_fail++; $display("FAIL after_abort got we %b reg %0d data %h want 1 3 0badcafe",
                               rf_we, rf_reg, rf_data);
        end
        tick();
    endtask

    initial begin
        reset           = 1'b1;
        start           = 1'b0;
        write_reg_rd    = 5'd0;
        wb_src          = 2'd0;
        alu_result      = 32'd0;
        link_addr       = 32'd0;
        load_type       = 3'd0;
        byte_offset     = 2'd0;
        rt_old          = 32'd0;
        mem_readdata    = 32'd0;
        mem_waitrequest = 1'b0;
        test_reset();
        test_alu_write();
        test_lb_wait();
        test_merge();
        test_no_write();
        test_link();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Write-back stage of the multicycle MIPS core. It sits directly downstream of `destination_reg_selector` and upstream of the register file. On a `start` pulse it latches the chosen destination register and the write-back source. For loads it waits for the memory read handshake, then formats the data (byte/half extension, LWL/LWR merge). It then issues exactly one register-file write strobe and signals completion to the control FSM.

## Interface
Parameters: none (32-bit datapath, 5-bit register index are fixed).

- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  launch write-back; sampled only in IDLE
- `write_reg_rd`  in  5  destination register from `destination_reg_selector`
- `wb_src`  in  2  0 = ALU result, 1 = memory load, 2 = link address, 3 = no write
- `alu_result`  in  32  ALU output
- `link_addr`  in  32  return address (PC+8)
- `load_type`  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR; 7 treated as LW
- `byte_offset`  in  2  effective address bits [1:0]
- `rt_old`  in  32  current rt contents, used by LWL/LWR merge
- `mem_readdata`  in  32  load data; byte 0 (lowest address) in bits [31:24]
- `mem_waitrequest`  in  1  high = readdata not yet valid
- `busy`  out  1  high in WAIT_MEM and WRITE
- `done`  out  1  one-cycle pulse in WRITE
- `rf_write_enable`  out  1  register-file write strobe
- `rf_write_reg`  out  5  latched destination index
- `rf_write_data`  out  32  formatted write data

## Operation
- FSM states: IDLE, WAIT_MEM, WRITE.
- IDLE with `start`=1: latch `write_reg_rd`, `wb_src`, `load_type`, `byte_offset`, `rt_old`, and the selected data (ALU or link). Next state is WAIT_MEM if `wb_src`=1, otherwise WRITE.
- WAIT_MEM: each edge where `mem_waitrequest`=0, capture `mem_readdata` and go to WRITE. Otherwise stay; no timeout.
- WRITE:
  - Drive `done`=1.
  - `rf_write_enable`=1 unless the latched `wb_src`=3 or the latched register is 0.
  - Return to IDLE on the next edge.
- `start` is ignored outside IDLE; latched values are not disturbed.
- Load formatting, with k = byte_offset and M = captured readdata:
  - LW: M.
  - LB/LBU: byte M[31-8k : 24-8k], sign- or zero-extended.
  - LH/LHU: M[31:16] if k[1]=0, else M[15:0], sign- or zero-extended. k[0] is ignored; misalignment is not detected here.
  - LWL: (M << 8k) | (rt_old & (2^(8k)-1)).
  - LWR: (rt_old & ~(2^(8(k+1))-1)) | (M >> 8(3-k)). For k=3 the result is M.
- Register 0 is never written. The `done` handshake is unchanged in that case.

## Timing
- Reset: state IDLE; all latches 0. `busy`, `done`, `rf_write_enable` = 0; `rf_write_reg` = 0; `rf_write_data` = 0.
- Reset asserted in any state returns to IDLE on that edge. No write strobe is produced for an aborted operation.
- Non-load: `start` sampled at edge E0. WRITE occupies the cycle E0→E1 and the register file writes at E1. Latency is 1 cycle.
- Load with `mem_waitrequest`=0 at E1: data captured at E1, WRITE during E1→E2. Minimum latency is 2 cycles, plus 1 cycle per extra waitrequest cycle.
- Outputs in WRITE are driven from latched state and the FSM only. They do not depend combinationally on current inputs.
- `rf_write_reg` and `rf_write_data` hold their last values outside WRITE; only `rf_write_enable` qualifies them.
- `start` asserted in the same cycle as WRITE is ignored. The earliest next accepted `start` is the IDLE cycle after.

## Test plan
- ALU write: `write_reg_rd`=8, `wb_src`=0, `alu_result`=0x12345678, `start` pulse → next cycle `rf_write_enable`=1, reg 8, data 0x12345678, `done`=1; IDLE after.
- LB with wait: `wb_src`=1, `load_type`=1, k=2, `mem_readdata`=0x11228344, `mem_waitrequest` high 3 cycles → `busy` held. Write data 0xFFFFFF83 one cycle after waitrequest drops. LBU → 0x00000083.
- LWL/LWR merge: `mem_readdata`=0xAABBCCDD, `rt_old`=0x11223344, k=1 → LWL 0xBBCCDD44; LWR 0x1122AABB.
- $zero and no-write: `write_reg_rd`=0 with `wb_src`=0, and separately `wb_src`=3 → `done` pulses, `rf_write_enable` stays 0.
- Link: `wb_src`=2, `write_reg_rd`=31, `link_addr`=0xBFC00008 → reg 31 written with 0xBFC00008.
- Reset in WAIT_MEM, then `mem_waitrequest`=0 → no write strobe; outputs 0; a new `start` is accepted normally.
